// File: rtl/fp_subtractor_seq.sv
// rtl/fp_subtractor_seq.sv - multi-cycle IEEE-754 subtractor, res = num0 - num1
// Purpose: binary32/binary64 subtraction with a valid/ready handshake and a
//   bit-serial align/normalize FSM (IDLE, CHECK, ALIGN, ARITH, NORM, ROUND, DONE).
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (num0 minuend, num1 subtrahend)
//   out_valid/out_ready result handshake (res held stable until consumed)
//   overflow, zero, NaN, precisionLost, flagRaised  status flags, valid with out_valid
module fp_subtractor_seq #(
  parameter int BIT_SIZE            = 32,
  parameter int ROUNDING_TYPE       = 0,
  parameter bit ENABLE_FLAGS_MASTER = 1'b1,
  parameter bit ENABLE_FLAGS_COMMON = 1'b1,
  parameter bit ENABLE_FLAGS_OF     = 1'b1,
  parameter bit ENABLE_FLAGS_ZERO   = 1'b1,
  parameter bit ENABLE_FLAGS_NaN    = 1'b1,
  parameter bit ENABLE_FLAGS_PLost  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] num0,
  input  logic [BIT_SIZE-1:0] num1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] res,
  output logic                overflow,
  output logic                zero,
  output logic                NaN,
  output logic                precisionLost,
  output logic                flagRaised
);

  if (BIT_SIZE != 32 && BIT_SIZE != 64) begin : gBadSize
    $error("fp_subtractor_seq: BIT_SIZE must be 32 or 64");
  end

  localparam int EXP_SIZE      = (BIT_SIZE == 64) ? 11 : 8;
  localparam int FRACTION_SIZE = BIT_SIZE - EXP_SIZE - 1;
  // Working mantissa: {carry, hidden, fraction, guard, round, sticky}
  localparam int MW = FRACTION_SIZE + 5;
  // Exponent carries one extra bit so carry/round-up past the max is visible
  localparam int XW = EXP_SIZE + 1;
  localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_SIZE{1'b1}}};
  localparam logic [BIT_SIZE-1:0] QNAN =
    {1'b0, {EXP_SIZE{1'b1}}, 1'b1, {(FRACTION_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CHECK, ALIGN, ARITH, NORM, ROUND, DONE} stateT;
  stateT state, nextState;

  // Captured operands; bSign is already inverted so the rest is a plain add
  logic                     aSign, bSign;
  logic [EXP_SIZE-1:0]      aExp, bExp;
  logic [FRACTION_SIZE-1:0] aFrac, bFrac;

  // Working datapath
  logic          bigSign, effSub;
  logic [XW-1:0] expR, diffR;
  logic [MW-1:0] accR, smallR;

  // Registered result
  logic [BIT_SIZE-1:0] resR;
  logic                ovfR, zeroR, nanR, plR;

  // Combinational helpers
  logic                     aNaN, bNaN, aInf, bInf, aGeB;
  logic [XW-1:0]            aEffExp, bEffExp, diffC, bigEffExp;
  logic [MW-1:0]            aMant, bMant, bigMant, smallMant, sumC;
  logic                     specialC, spNan, spOvf, spZero;
  logic [BIT_SIZE-1:0]      specialRes;
  logic                     collapse, roundUp, expOvf;
  logic [FRACTION_SIZE+1:0] mantRnd;
  logic [FRACTION_SIZE:0]   mantFin;
  logic [XW-1:0]            expFin;
  logic [EXP_SIZE-1:0]      expField;
  logic [FRACTION_SIZE-1:0] fracField;
  logic [BIT_SIZE-1:0]      roundedRes;

  always_comb begin
    aNaN = (aExp == '1) && (aFrac != '0);
    bNaN = (bExp == '1) && (bFrac != '0);
    aInf = (aExp == '1) && (aFrac == '0);
    bInf = (bExp == '1) && (bFrac == '0);
    aGeB = {aExp, aFrac} >= {bExp, bFrac};

    // Exponent field 0 means hidden bit 0 with effective exponent 1
    aEffExp = (aExp == '0) ? XW'(1) : {1'b0, aExp};
    bEffExp = (bExp == '0) ? XW'(1) : {1'b0, bExp};
    aMant   = {1'b0, (aExp != '0), aFrac, 3'b000};
    bMant   = {1'b0, (bExp != '0), bFrac, 3'b000};

    bigEffExp = aGeB ? aEffExp : bEffExp;
    bigMant   = aGeB ? aMant : bMant;
    smallMant = aGeB ? bMant : aMant;
    diffC     = aGeB ? (aEffExp - bEffExp) : (bEffExp - aEffExp);

    specialC   = 1'b1;
    specialRes = '0;
    spNan      = 1'b0;
    spOvf      = 1'b0;
    spZero     = 1'b0;
    if (aNaN || bNaN) begin
      specialRes = QNAN;
      spNan      = 1'b1;
    end else if (aInf && bInf && (aSign != bSign)) begin
      specialRes = QNAN;
      spNan      = 1'b1;
    end else if (aInf) begin
      specialRes = {aSign, {EXP_SIZE{1'b1}}, {FRACTION_SIZE{1'b0}}};
      spOvf      = 1'b1;
    end else if (bInf) begin
      specialRes = {bSign, {EXP_SIZE{1'b1}}, {FRACTION_SIZE{1'b0}}};
      spOvf      = 1'b1;
    end else if ((aExp == bExp) && (aFrac == bFrac) && (aSign != bSign)) begin
      spZero = 1'b1;
    end else begin
      specialC = 1'b0;
    end

    // Beyond FRACTION_SIZE+3 every bit lands below sticky anyway
    collapse = diffR > XW'(FRACTION_SIZE + 3);
    sumC     = effSub ? (accR - smallR) : (accR + smallR);

    roundUp = (ROUNDING_TYPE == 1) && accR[2];
    mantRnd = {1'b0, accR[MW-2:3]} + {{(FRACTION_SIZE+1){1'b0}}, roundUp};
    if (mantRnd[FRACTION_SIZE+1]) begin
      mantFin = mantRnd[FRACTION_SIZE+1:1];
      expFin  = expR + XW'(1);
    end else begin
      mantFin = mantRnd[FRACTION_SIZE:0];
      expFin  = expR;
    end
    expOvf = mantFin[FRACTION_SIZE] && (expFin >= EXP_MAX);
    if (expOvf) begin
      expField  = '1;
      fracField = '0;
    end else begin
      // No hidden bit after normalization means subnormal: field 0
      expField  = mantFin[FRACTION_SIZE] ? expFin[EXP_SIZE-1:0] : '0;
      fracField = mantFin[FRACTION_SIZE-1:0];
    end
    roundedRes = {bigSign, expField, fracField};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) nextState = CHECK;
      end
      CHECK: begin
        if (specialC)          nextState = DONE;
        else if (diffC == '0)  nextState = ARITH;
        else                   nextState = ALIGN;
      end
      ALIGN: begin
        if (collapse || diffR == XW'(1)) nextState = ARITH;
      end
      ARITH: begin
        if (sumC == '0)
          nextState = DONE;
        else if (sumC[MW-1] || (!sumC[MW-2] && expR > XW'(1)))
          nextState = NORM;
        else
          nextState = ROUND;
      end
      NORM: begin
        // Leave after the carry shift, or once this left shift lands the
        // hidden bit or reaches the subnormal exponent
        if (accR[MW-1] || accR[MW-3] || expR == XW'(2)) nextState = ROUND;
      end
      ROUND: nextState = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resR  <= '0;
      ovfR  <= 1'b0;
      zeroR <= 1'b0;
      nanR  <= 1'b0;
      plR   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aSign <= num0[BIT_SIZE-1];
            aExp  <= num0[BIT_SIZE-2:FRACTION_SIZE];
            aFrac <= num0[FRACTION_SIZE-1:0];
            bSign <= ~num1[BIT_SIZE-1];
            bExp  <= num1[BIT_SIZE-2:FRACTION_SIZE];
            bFrac <= num1[FRACTION_SIZE-1:0];
          end
        end
        CHECK: begin
          accR    <= bigMant;
          smallR  <= smallMant;
          expR    <= bigEffExp;
          diffR   <= diffC;
          bigSign <= aGeB ? aSign : bSign;
          effSub  <= aSign ^ bSign;
          if (specialC) begin
            resR  <= specialRes;
            nanR  <= spNan;
            ovfR  <= spOvf;
            zeroR <= spZero;
            plR   <= 1'b0;
          end
        end
        ALIGN: begin
          if (collapse) begin
            smallR <= {{(MW-1){1'b0}}, |smallR};
            diffR  <= '0;
          end else begin
            smallR <= {1'b0, smallR[MW-1:2], smallR[1] | smallR[0]};
            diffR  <= diffR - XW'(1);
          end
        end
        ARITH: begin
          accR <= sumC;
          if (sumC == '0) begin
            resR  <= '0;
            zeroR <= 1'b1;
          end
        end
        NORM: begin
          if (accR[MW-1]) begin
            accR <= {1'b0, accR[MW-1:2], accR[1] | accR[0]};
            expR <= expR + XW'(1);
          end else begin
            accR <= {accR[MW-2:0], 1'b0};
            expR <= expR - XW'(1);
          end
        end
        ROUND: begin
          resR  <= roundedRes;
          ovfR  <= expOvf;
          zeroR <= 1'b0;
          nanR  <= 1'b0;
          plR   <= |accR[2:0];
        end
        DONE: begin
          if (out_ready) begin
            ovfR  <= 1'b0;
            zeroR <= 1'b0;
            nanR  <= 1'b0;
            plR   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    res           = resR;
    overflow      = ENABLE_FLAGS_MASTER && ENABLE_FLAGS_OF    && out_valid && ovfR;
    zero          = ENABLE_FLAGS_MASTER && ENABLE_FLAGS_ZERO  && out_valid && zeroR;
    NaN           = ENABLE_FLAGS_MASTER && ENABLE_FLAGS_NaN   && out_valid && nanR;
    precisionLost = ENABLE_FLAGS_MASTER && ENABLE_FLAGS_PLost && out_valid && plR;
    flagRaised    = ENABLE_FLAGS_MASTER && ENABLE_FLAGS_COMMON &&
                    (overflow || zero || NaN || precisionLost);
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// tb/tb_fp_subtractor_seq.sv - directed scoreboard bench for fp_subtractor_seq (binary32)
// Two instances share stimulus: dut0 truncates, dut1 rounds half-up.
module tb_fp_subtractor_seq;

  localparam int LAT_LIMIT = 2 * 23 + 10;
  // Flag vectors: {overflow, zero, NaN, precisionLost, flagRaised}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_ZERO = 5'b01001;
  localparam logic [4:0] F_NAN  = 5'b00101;
  localparam logic [4:0] F_OVF  = 5'b10001;
  localparam logic [4:0] F_PL   = 5'b00011;

  logic clk = 1'b0;
  logic rst, inValid, outReady;
  logic [31:0] num0, num1, res0, res1;
  logic inReady0, inReady1, outValid0, outValid1;
  logic ovf0, zero0, nan0, pl0, fr0;
  logic ovf1, zero1, nan1, pl1, fr1;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] res0;
    logic [31:0] res1;
    logic [4:0]  fl0;
    logic [4:0]  fl1;
    bit          special;
  } sbEntry;
  sbEntry sbQ[$];

  always #5 clk = ~clk;

  fp_subtractor_seq #(.BIT_SIZE(32), .ROUNDING_TYPE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady0),
    .num0(num0), .num1(num1), .out_valid(outValid0), .out_ready(outReady),
    .res(res0), .overflow(ovf0), .zero(zero0), .NaN(nan0),
    .precisionLost(pl0), .flagRaised(fr0)
  );

  fp_subtractor_seq #(.BIT_SIZE(32), .ROUNDING_TYPE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady1),
    .num0(num0), .num1(num1), .out_valid(outValid1), .out_ready(outReady),
    .res(res1), .overflow(ovf1), .zero(zero1), .NaN(nan1),
    .precisionLost(pl1), .flagRaised(fr1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sendOp(input logic [31:0] a, input logic [31:0] b);
    int waitCycles = 0;
    @(negedge clk);
    while (!(inReady0 && inReady1) && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    check("in_ready before issue", {31'b0, inReady0 & inReady1}, 32'd1);
    num0    = a;
    num1    = b;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic getResult(input string name, input bit hold);
    sbEntry e;
    int lat = 1;
    logic [31:0] heldRes;
    while (!outValid0 && lat < LAT_LIMIT + 4) begin
      @(negedge clk);
      lat++;
    end
    check({name, " sb depth"}, sbQ.size(), 32'd1);
    e = sbQ.pop_front();
    check({name, " valid"}, {30'b0, outValid0, outValid1}, 32'd3);
    check({name, " res rt0"}, res0, e.res0);
    check({name, " res rt1"}, res1, e.res1);
    check({name, " flags rt0"}, {27'b0, ovf0, zero0, nan0, pl0, fr0}, {27'b0, e.fl0});
    check({name, " flags rt1"}, {27'b0, ovf1, zero1, nan1, pl1, fr1}, {27'b0, e.fl1});
    if (e.special) check({name, " latency"}, lat, 32'd2);
    else           check({name, " latency bound"}, {31'b0, lat <= LAT_LIMIT}, 32'd1);
    if (hold) begin
      heldRes = res0;
      repeat (5) begin
        @(negedge clk);
        check({name, " hold valid/in_ready"}, {30'b0, outValid0, inReady0}, 32'd2);
        check({name, " hold res"}, res0, heldRes);
        check({name, " hold flags"}, {27'b0, ovf0, zero0, nan0, pl0, fr0}, {27'b0, e.fl0});
      end
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    check({name, " released"}, {30'b0, inReady0, outValid0}, 32'd2);
  endtask

  task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r0, input logic [31:0] r1,
                       input logic [4:0] f0, input logic [4:0] f1,
                       input bit special, input bit hold);
    sbQ.push_back('{r0, r1, f0, f1, special});
    sendOp(a, b);
    getResult(name, hold);
  endtask

  initial begin
    int pulses;
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    num0     = '0;
    num1     = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready/out_valid", {30'b0, inReady0, outValid0}, 32'd0);
    check("reset res", res0, 32'h0);
    check("reset flags", {27'b0, ovf0, zero0, nan0, pl0, fr0}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", {31'b0, inReady0}, 32'd1);

    runOp("3-1",       32'h40400000, 32'h3F800000, 32'h40000000, 32'h40000000, F_NONE, F_NONE, 1'b0, 1'b0);
    runOp("x-x",       32'h3F800000, 32'h3F800000, 32'h00000000, 32'h00000000, F_ZERO, F_ZERO, 1'b1, 1'b0);
    runOp("subnormal", 32'h00800000, 32'h00400000, 32'h00400000, 32'h00400000, F_NONE, F_NONE, 1'b0, 1'b0);
    runOp("2^25-1",    32'h4C000000, 32'h3F800000, 32'h4BFFFFFF, 32'h4C000000, F_PL,   F_PL,   1'b0, 1'b0);
    runOp("1-(-1)",    32'h3F800000, 32'hBF800000, 32'h40000000, 32'h40000000, F_NONE, F_NONE, 1'b0, 1'b0);
    runOp("1-2",       32'h3F800000, 32'h40000000, 32'hBF800000, 32'hBF800000, F_NONE, F_NONE, 1'b0, 1'b0);
    runOp("overflow",  32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 32'h7F800000, F_OVF,  F_OVF,  1'b0, 1'b0);
    runOp("nan op",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, F_NAN,  F_NAN,  1'b1, 1'b0);
    runOp("1-inf",     32'h3F800000, 32'h7F800000, 32'hFF800000, 32'hFF800000, F_OVF,  F_OVF,  1'b1, 1'b0);
    runOp("inf-inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, F_NAN,  F_NAN,  1'b1, 1'b1);

    sendOp(32'h4B000000, 32'h3F800001);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort during rst", {30'b0, inReady0, outValid0}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort in_ready", {30'b0, inReady0, inReady1}, 32'd3);
    pulses = 0;
    repeat (LAT_LIMIT + 4) begin
      @(negedge clk);
      if (outValid0 || outValid1) pulses++;
    end
    check("abort no out_valid", pulses, 32'd0);

    runOp("after abort", 32'h4B000000, 32'h3F800001, 32'h4AFFFFFD, 32'h4AFFFFFE, F_PL, F_PL, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
